// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: ALU path plus FIFO-buffered load path.
// Optional forwarding port enabled by defining RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                     Wrclk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [ADDR_WIDTH-1:0]    alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  output logic                     alu_ready,
  input  logic                     lsu_valid,
  input  logic [ADDR_WIDTH-1:0]    lsu_rd,
  input  logic [DATA_WIDTH-1:0]    lsu_data,
  output logic                     lsu_ready,
  output logic [ADDR_WIDTH-1:0]    Rw,
  output logic [DATA_WIDTH-1:0]    busW,
  output logic                     RegWr,
  output logic [2**ADDR_WIDTH-1:0] pend_mask,
  input  logic [ADDR_WIDTH-1:0]    fwd_addr,
  output logic                     fwd_hit,
  output logic [DATA_WIDTH-1:0]    fwd_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  typedef enum logic {
    ALU_PRI,
    LSU_FORCE
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_t;

  wb_t                   mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld;
  logic [PW:0]           wptr;
  logic [PW:0]           rptr;
  state_t                state;
  logic [SW-1:0]         starve;
  logic [SW-1:0]         starve_nx;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  alu_win;
  wb_t                   head;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) &&
                 (wptr[PW-1:0] == rptr[PW-1:0]);
  assign head  = mem[rptr[PW-1:0]];

  assign lsu_ready = rst_n && !full;
  assign alu_ready = rst_n && (state == ALU_PRI);
  assign push      = lsu_valid && lsu_ready;
  assign alu_win   = alu_valid && alu_ready;
  // In LSU_FORCE alu_ready is low, so the head pops unconditionally.
  assign pop       = rst_n && !empty && !alu_win;

  always_ff @(posedge Wrclk) begin
    if (push)
      mem[wptr[PW-1:0]] <= '{rd: lsu_rd, data: lsu_data};
  end

  always_ff @(posedge Wrclk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      vld  <= '0;
    end else begin
      if (push) begin
        vld[wptr[PW-1:0]] <= 1'b1;
        wptr              <= wptr + (PW+1)'(1);
      end
      if (pop) begin
        vld[rptr[PW-1:0]] <= 1'b0;
        rptr              <= rptr + (PW+1)'(1);
      end
    end
  end

  assign starve_nx = starve + SW'(1);

  always_ff @(posedge Wrclk) begin
    if (!rst_n) begin
      state  <= ALU_PRI;
      starve <= '0;
    end else begin
      unique case (state)
        ALU_PRI: begin
          if (pop || empty) begin
            starve <= '0;
          end else if (alu_win) begin
            starve <= starve_nx;
            if (starve_nx == SLIM)
              state <= LSU_FORCE;
          end
        end
        LSU_FORCE: begin
          if (pop || empty) begin
            state  <= ALU_PRI;
            starve <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Wrclk) begin
    if (!rst_n) begin
      RegWr <= 1'b0;
      Rw    <= '0;
      busW  <= '0;
    end else if (alu_win) begin
      RegWr <= |alu_rd;
      Rw    <= alu_rd;
      busW  <= alu_data;
    end else if (pop) begin
      RegWr <= |head.rd;
      Rw    <= head.rd;
      busW  <= head.data;
    end else begin
      RegWr <= 1'b0;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (vld[i])
        pend_mask[mem[i].rd] = 1'b1;
    pend_mask[0] = 1'b0;
  end

`ifdef RF_WB_BYPASS_EN
  assign fwd_hit  = rst_n && RegWr && (Rw == fwd_addr) &&
                    (fwd_addr != '0);
  assign fwd_data = fwd_hit ? busW : '0;
`else
  logic fwd_unused;
  assign fwd_unused = ^fwd_addr;
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule
